mips_mem_responder: RTL and testbench

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_pkg.sv | 13 +
 rtl/mips_word_ram.sv | 26 ++
 rtl/mips_mem_responder.sv | 119 +++++++++++
 tb/tb_mips_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared state codes and widths for the MIPS memory responder.
package mips_mem_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mips_word_ram.sv
// Word-wide single-port storage: synchronous write, combinational read.
module mips_word_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata_c = mem[idx];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder with fixed wait states and misaligned-access detection.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            count_state
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    logic                    cur_we_c;
    logic [ADDR_WIDTH-1:0]   cur_addr_c;
    logic                    misaligned_c;
    logic                    ram_we_c;
    logic [DATA_WIDTH-1:0]   ram_rdata_c;

    // In IDLE the live request is the one being accepted; otherwise use the latched copy
    always_comb begin
        cur_we_c     = lat_we;
        cur_addr_c   = lat_addr;
        if (state == IDLE) begin
            cur_we_c   = req_we;
            cur_addr_c = req_addr;
        end
        misaligned_c = (cur_addr_c[1:0] != 2'b00);
        ram_we_c     = (state == RESP) && lat_we && (lat_addr[1:0] == 2'b00) && !reset;
    end

    mips_word_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c),
        .idx     (cur_addr_c[ADDR_WIDTH-1:2]),
        .wdata   (lat_wdata),
        .rdata_c (ram_rdata_c)
    );

    // Handshake FSM, wait counter, request latch and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= misaligned_c;
                            rsp_rdata <= (!cur_we_c && !misaligned_c) ? ram_rdata_c : '0;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= misaligned_c;
                        rsp_rdata <= (!cur_we_c && !misaligned_c) ? ram_rdata_c : '0;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign count_state = 2'(state);

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench: one responder with two wait states, one with none.
module tb_mips_mem_responder;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 8;
    localparam int unsigned NW     = 64;
    localparam int unsigned WAIT_A = 2;
    localparam int unsigned WAIT_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_a, reset_b, valid_a, valid_b;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          a_ready, a_valid, a_err;
    logic [DW-1:0] a_rdata;
    logic [1:0]    a_state;
    logic          b_ready, b_valid, b_err;
    logic [DW-1:0] b_rdata;
    logic [1:0]    b_state;

    mips_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk(clk), .reset(reset_a), .req_valid(valid_a), .req_ready(a_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err), .count_state(a_state)
    );

    mips_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk(clk), .reset(reset_b), .req_valid(valid_b), .req_ready(b_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .count_state(b_state)
    );

    int            sel;
    logic          o_ready, o_valid, o_err;
    logic [DW-1:0] o_rdata;
    logic [1:0]    o_state;

    always_comb begin
        o_ready = (sel == 0) ? a_ready : b_ready;
        o_valid = (sel == 0) ? a_valid : b_valid;
        o_err   = (sel == 0) ? a_err   : b_err;
        o_rdata = (sel == 0) ? a_rdata : b_rdata;
        o_state = (sel == 0) ? a_state : b_state;
    end

    // Reference memory per instance: a word per aligned address
    logic [DW-1:0] model [2][NW];
    int passed, total;

    function automatic int exp_lat(int s);
        return (s == 0) ? int'(WAIT_A) + 1 : int'(WAIT_B) + 1;
    endfunction

    // Drive one request from an idle negedge; return the response and any protocol slips
    task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       output logic [DW-1:0] rd, output logic err, output int lat, output int bad);
        bad = 0; lat = 0; rd = '0; err = 1'b0;
        if (o_ready !== 1'b1) bad++;
        req_we = we; req_addr = addr; req_wdata = wd;
        if (sel == 0) valid_a = 1'b1; else valid_b = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
        for (int n = 1; n <= 24 && lat == 0; n++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                lat = n; rd = o_rdata; err = o_err;
            end else if (o_rdata !== '0 || o_err !== 1'b0) begin
                bad++;
            end
            if (o_ready === 1'b1 && o_state !== 2'd0) bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset(input int s);
        sel = s;
        if (s == 0) reset_a = 1'b1; else reset_b = 1'b1;
        @(negedge clk);
        total++; if (o_ready !== 1'b1) $display("FAIL reset_ready_during s=%0d got %b want 1", s, o_ready); else passed++;
        @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);
        total++; if (o_ready !== 1'b1) $display("FAIL reset_ready s=%0d got %b want 1", s, o_ready); else passed++;
        total++; if (o_valid !== 1'b0) $display("FAIL reset_valid s=%0d got %b want 0", s, o_valid); else passed++;
        total++; if (o_rdata !== '0) $display("FAIL reset_rdata s=%0d got %h want 0", s, o_rdata); else passed++;
        total++; if (o_err !== 1'b0) $display("FAIL reset_err s=%0d got %b want 0", s, o_err); else passed++;
        total++; if (o_state !== 2'd0) $display("FAIL reset_state s=%0d got %0d want 0", s, o_state); else passed++;
    endtask

    task automatic test_fill(input int s);
        logic [DW-1:0] rd, wd; logic err; int lat, bad;
        sel = s;
        for (int i = 0; i < int'(NW); i++) begin
            wd = $urandom;
            txn(1'b1, AW'(i * 4), wd, rd, err, lat, bad);
            total++;
            if ({rd, err, 32'(lat), 32'(bad)} !== {32'h0, 1'b0, 32'(exp_lat(s)), 32'h0})
                $display("FAIL fill s=%0d word %0d: got rdata=%h err=%b lat=%0d bad=%0d, want 0/0/%0d/0",
                         s, i, rd, err, lat, bad, exp_lat(s));
            else passed++;
            model[s][i] = wd;
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] rd; logic err; int lat, bad;
        sel = 0;
        txn(1'b1, 8'h08, 32'h0000_0014, rd, err, lat, bad);
        model[0][2] = 32'h0000_0014;
        total++; if (lat !== 3) $display("FAIL basic_wr_lat got %0d want 3", lat); else passed++;
        total++; if ({rd, err} !== {32'h0, 1'b0}) $display("FAIL basic_wr_rsp got %h/%b want 0/0", rd, err); else passed++;
        txn(1'b0, 8'h08, 32'h0, rd, err, lat, bad);
        total++; if (lat !== 3) $display("FAIL basic_rd_lat got %0d want 3", lat); else passed++;
        total++; if (rd !== 32'h0000_0014) $display("FAIL basic_rd_data got %h want 00000014", rd); else passed++;
        total++; if (err !== 1'b0) $display("FAIL basic_rd_err got %b want 0", err); else passed++;
        total++; if (bad !== 0) $display("FAIL basic_protocol got %0d want 0", bad); else passed++;
    endtask

    task automatic test_misaligned();
        logic [DW-1:0] rd; logic err; int lat, bad;
        sel = 0;
        txn(1'b1, 8'h02, 32'hDEAD_BEEF, rd, err, lat, bad);
        total++; if ({rd, err, 32'(lat)} !== {32'h0, 1'b1, 32'd3})
            $display("FAIL misal_wr got rdata=%h err=%b lat=%0d want 0/1/3", rd, err, lat); else passed++;
        txn(1'b0, 8'h00, 32'h0, rd, err, lat, bad);
        total++; if ({rd, err} !== {model[0][0], 1'b0})
            $display("FAIL misal_word0 got %h/%b want %h/0", rd, err, model[0][0]); else passed++;
        txn(1'b0, 8'h05, 32'h0, rd, err, lat, bad);
        total++; if ({rd, err} !== {32'h0, 1'b1})
            $display("FAIL misal_rd got %h/%b want 0/1", rd, err); else passed++;
    endtask

    task automatic test_random(input int s, input int count);
        logic [DW-1:0] rd, wd, er; logic err, ee, we; logic [AW-1:0] a; int lat, bad;
        sel = s;
        for (int i = 0; i < count; i++) begin
            we = 1'($urandom); a = AW'($urandom); wd = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            ee = (int'(a) % 4) != 0;
            er = (!we && !ee) ? model[s][int'(a) / 4] : 32'h0;
            txn(we, a, wd, rd, err, lat, bad);
            total++;
            if ({rd, err, 32'(lat), 32'(bad)} !== {er, ee, 32'(exp_lat(s)), 32'h0})
                $display("FAIL rand s=%0d #%0d we=%b addr=%h: got rdata=%h err=%b lat=%0d bad=%0d, want %h/%b/%0d/0",
                         s, i, we, a, rd, err, lat, bad, er, ee, exp_lat(s));
            else passed++;
            if (we && !ee) model[s][int'(a) / 4] = wd;
        end
    endtask

    task automatic test_reset_abort();
        logic [DW-1:0] rd; logic err; int lat, bad, pulses;
        sel = 0;
        req_we = 1'b1; req_addr = 8'h0C; req_wdata = 32'h0000_00FF; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        @(negedge clk);
        total++; if (o_state !== 2'd1) $display("FAIL abort_in_wait got state %0d want 1", o_state); else passed++;
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        total++; if ({o_state, o_valid} !== {2'd0, 1'b0})
            $display("FAIL abort_state got state=%0d valid=%b want 0/0", o_state, o_valid); else passed++;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            if (o_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        total++; if (pulses !== 0) $display("FAIL abort_no_rsp got %0d pulses want 0", pulses); else passed++;
        txn(1'b0, 8'h0C, 32'h0, rd, err, lat, bad);
        total++; if ({rd, err} !== {model[0][3], 1'b0})
            $display("FAIL abort_old_value got %h/%b want %h/0", rd, err, model[0][3]); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc[$]; int pulses, bad, k;
        logic [DW-1:0] rd; logic err; int lat, tb;
        sel = 0; pulses = 0; bad = 0; k = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_valid === 1'b1) pulses++;
            if ((o_ready === 1'b1) != (o_state === 2'd0)) bad++;
            if (o_ready === 1'b1) begin
                if (k < 5) begin
                    acc.push_back(c);
                    req_we = 1'b1; req_addr = AW'(8'h40 + k * 4); req_wdata = $urandom;
                    model[0][16 + k] = req_wdata;
                    valid_a = 1'b1;
                    k++;
                end else begin
                    valid_a = 1'b0;
                end
            end else begin
                req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
            end
            @(negedge clk);
        end
        valid_a = 1'b0;
        total++; if (k !== 5) $display("FAIL b2b_accepts got %0d want 5", k); else passed++;
        total++; if (pulses !== 5) $display("FAIL b2b_rsp_pulses got %0d want 5", pulses); else passed++;
        total++; if (bad !== 0) $display("FAIL b2b_ready_vs_state got %0d slips want 0", bad); else passed++;
        for (int i = 1; i < acc.size(); i++) begin
            total++; if (acc[i] - acc[i-1] !== 4)
                $display("FAIL b2b_interval %0d got %0d want 4", i, acc[i] - acc[i-1]); else passed++;
        end
        for (int i = 15; i <= 21; i++) begin
            txn(1'b0, AW'(i * 4), 32'h0, rd, err, lat, tb);
            total++; if ({rd, err} !== {model[0][i], 1'b0})
                $display("FAIL b2b_readback word %0d got %h/%b want %h/0", i, rd, err, model[0][i]); else passed++;
        end
    endtask

    task automatic test_zero_wait();
        logic [DW-1:0] rd; logic err; int lat, bad;
        sel = 1;
        txn(1'b1, 8'hFC, 32'h0000_001E, rd, err, lat, bad);
        model[1][63] = 32'h0000_001E;
        total++; if ({rd, err, 32'(lat)} !== {32'h0, 1'b0, 32'd1})
            $display("FAIL zw_wr got rdata=%h err=%b lat=%0d want 0/0/1", rd, err, lat); else passed++;
        txn(1'b0, 8'hFC, 32'h0, rd, err, lat, bad);
        total++; if (lat !== 1) $display("FAIL zw_rd_lat got %0d want 1", lat); else passed++;
        total++; if ({rd, err} !== {32'h0000_001E, 1'b0})
            $display("FAIL zw_rd_data got %h/%b want 0000001e/0", rd, err); else passed++;
        total++; if (bad !== 0) $display("FAIL zw_protocol got %0d want 0", bad); else passed++;
    endtask

    initial begin
        passed = 0; total = 0; sel = 0;
        valid_a = 1'b0; valid_b = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        reset_a = 1'b1; reset_b = 1'b1;
        repeat (3) @(negedge clk);
        test_reset(0);
        test_reset(1);
        test_fill(0);
        test_fill(1);
        test_basic();
        test_misaligned();
        test_random(0, 60);
        test_reset_abort();
        test_back_to_back();
        test_zero_wait();
        test_random(1, 40);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
